uart_receiver: RTL and testbench



---
 rtl/uart_receiver.sv | 198 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 2-flop synchroniser, mid-bit sampling FSM and a
// valid/ready holding register (4-entry FIFO when UART_RX_FIFO_EN is defined).
module uart_receiver #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FrameError,
  output logic       Overrun
);

  localparam int SymbolEdge = ClockFreq / BaudRate;
  localparam int SampleTime = SymbolEdge / 2;
  localparam int TimerW     = $clog2(SymbolEdge + 1);
  localparam logic [TimerW-1:0] SymbolLast = TimerW'(SymbolEdge - 1);
  localparam logic [TimerW-1:0] SampleLast = TimerW'(SampleTime - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  logic [1:0]        sync_q;
  logic              rx;
  state_t            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              commit_q, commit_d;
  logic              frame_error_q, frame_error_d;
  logic              overrun_q, overrun_d;
  logic              handshake;

  assign rx = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= 2'b11;
      state_q       <= S_IDLE;
      timer_q       <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      commit_q      <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], SIn};
      state_q       <= state_d;
      timer_q       <= timer_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      commit_q      <= commit_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TimerW'(1);
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    commit_d      = 1'b0;
    frame_error_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (timer_q == SampleLast) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == SymbolLast) begin
          timer_d   = '0;
          shift_d   = {rx, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == SymbolLast) begin
          timer_d = '0;
          if (rx) begin
            commit_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        timer_d = '0;
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign handshake  = DataOutValid && DataOutReady;
  assign FrameError = frame_error_q;
  assign Overrun    = overrun_q;

`ifdef UART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic [1:0] head_idx;
  logic       push;

  // NOTE: the entries are reset because an empty FIFO still drives DataOut
  // from the last-popped slot, which must read 0 straight after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = 1'b0;
    push      = commit_q && ((count_q != 3'd4) || handshake);
    if (commit_q && !push) overrun_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (handshake) rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, handshake})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Once empty, the read pointer has moved past the popped entry; show that one.
  assign head_idx     = (count_q == 3'd0) ? (rd_ptr_q - 2'd1) : rd_ptr_q;
  assign DataOut      = mem_q[head_idx];
  assign DataOutValid = (count_q != 3'd0);
`else
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // DataOut only ever moves on a commit; a handshake just clears the valid flag.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (handshake) valid_d = 1'b0;
    if (commit_q) begin
      if (valid_q && !handshake) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign DataOut      = data_q;
  assign DataOutValid = valid_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected bytes, a monitor
// pops and compares each time a new byte is presented. Bit period is scaled down.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BAUD     = 115_200;
  localparam int CLK_FREQ = 34_560_000;          // 300 clocks per bit
  localparam int SE       = CLK_FREQ / BAUD;
  localparam int ST       = SE / 2;
  localparam int LAT      = 2 + ST + 9 * SE + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       SIn;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       FrameError;
  logic       Overrun;

  uart_receiver #(.ClockFreq(CLK_FREQ), .BaudRate(BAUD)) dut (
    .clk          (clk),
    .reset        (reset),
    .SIn          (SIn),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .FrameError   (FrameError),
    .Overrun      (Overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  int fe_pulses = 0, fe_cycles = 0, ov_pulses = 0, ov_cycles = 0;
  int lat;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a byte is newly presented when valid rises, or stays high after a handshake.
  initial begin
    logic prev_valid, prev_hs, prev_fe, prev_ov;
    logic [7:0] e;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_fe = 1'b0; prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0; prev_hs = 1'b0; prev_fe = 1'b0; prev_ov = 1'b0;
      end else begin
        if (DataOutValid && (!prev_valid || prev_hs)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(DataOut), -1);
          end else begin
            e = exp_q.pop_front();
            check("data", int'(DataOut), int'(e));
          end
        end
        if (FrameError) begin
          fe_cycles++;
          if (!prev_fe) fe_pulses++;
        end
        if (Overrun) begin
          ov_cycles++;
          if (!prev_ov) ov_pulses++;
        end
        prev_valid = DataOutValid;
        prev_hs    = DataOutValid && DataOutReady;
        prev_fe    = FrameError;
        prev_ov    = Overrun;
      end
    end
  end

  // Called and returns at #1 after a rising edge; each bit spans SE edges.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    SIn = 1'b0;
    repeat (SE) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      SIn = b[i];
      repeat (SE) @(posedge clk);
      #1;
    end
    SIn = stop_ok;
    repeat (stop_ok ? SE : 3 * SE) @(posedge clk);
    #1;
    SIn = 1'b1;
    repeat (SE) @(posedge clk);
    #1;
  endtask

  task automatic read_one();
    DataOutReady = 1'b1;
    @(posedge clk);
    #1;
    DataOutReady = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && DataOutValid; i++) read_one();
    check("drained_valid", int'(DataOutValid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  int'(DataOut),      0);
    check({tag, "_valid"}, int'(DataOutValid), 0);
    check({tag, "_fe"},    int'(FrameError),   0);
    check({tag, "_ov"},    int'(Overrun),      0);
  endtask

  initial begin
    SIn = 1'b1;
    DataOutReady = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 0xA5 with ready low: latency from the first edge that samples SIn low.
    exp_q.push_back(8'hA5);
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 0; k < 2 * LAT; k++) begin
          @(posedge clk);
          #1;
          if (DataOutValid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("latency", lat, LAT);
    check("a5_no_fe", fe_pulses, 0);
    check("a5_no_ov", ov_pulses, 0);

    read_one();
    check("read_clears_valid", int'(DataOutValid), 0);
    check("read_keeps_data", int'(DataOut), 8'hA5);

    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check("data_3c", int'(DataOut), 8'h3C);
    read_one();

    // Overrun: storage fills without reads.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
`ifdef UART_RX_FIFO_EN
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
`else
    send_frame(8'h22, 1'b1);
`endif
    check("overrun_count", ov_pulses, 1);
    check("overrun_keeps_old", int'(DataOut), 8'h11);
    drain();

    // Short low glitch is rejected at the start-bit sample.
    SIn = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    SIn = 1'b1;
    repeat (11 * SE) @(posedge clk);
    #1;
    check("glitch_no_valid", int'(DataOutValid), 0);
    check("glitch_no_fe", fe_pulses, 0);

    // Bad stop bit, line held low for three bit times: one FrameError only.
    send_frame(8'h55, 1'b0);
    check("frame_error_count", fe_pulses, 1);
    check("frame_error_no_valid", int'(DataOutValid), 0);

    // Reset in the middle of bit 4 of a frame.
    SIn = 1'b0;
    repeat (SE) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      SIn = i[0];
      repeat (SE) @(posedge clk);
      #1;
    end
    SIn = 1'b1;
    repeat (SE / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("midframe_reset");
    reset = 1'b0;
    repeat (2 * SE) @(posedge clk);
    #1;
    check("abort_no_valid", int'(DataOutValid), 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    check("data_7e", int'(DataOut), 8'h7E);
    read_one();

    // Commit and handshake on the same edge.
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    exp_q.push_back(8'h69);
    fork
      send_frame(8'h69, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1;
        DataOutReady = 1'b1;
        @(posedge clk);
        #1;
        DataOutReady = 1'b0;
      end
    join
    check("same_edge_valid", int'(DataOutValid), 1);
    check("same_edge_data", int'(DataOut), 8'h69);
    check("same_edge_no_ov", ov_pulses, 1);
    read_one();
    repeat (4) @(posedge clk);
    #1;

    check("scoreboard_empty", exp_q.size(), 0);
    check("fe_one_cycle", fe_cycles, fe_pulses);
    check("ov_one_cycle", ov_cycles, ov_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
